// File: rtl/cpu_trace_tx.sv
// In-CPU trace transmitter: runs cycle/stall/flush counters and, on request,
// streams {cyc, stl, fls, pc, R0..R(NUM_REGS-1)} over a 32-bit valid/ready link.
module cpu_trace_tx #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic        snap_i,
  output logic [4:0]  reg_addr_o,
  input  logic [31:0] reg_data_i,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] tx_data_o,
  output logic        tx_last_o,
  output logic        busy_o,
  output logic        overrun_o
);

  localparam int LAST = NUM_REGS + 3;

  typedef enum logic [1:0] {IDLE, HDR, REGS} state_t;

  state_t           state;
  logic [5:0]       widx;
  logic [CNT_W-1:0] cyc, stl, fls;
  logic [CNT_W-1:0] cap_stl, cap_fls;
  logic [31:0]      cap_pc;
  logic             pending;

  logic             xfer, last_xfer, restart;
  logic [5:0]       nidx;
  logic [4:0]       addr_next;
  logic [31:0]      data_next;

  assign xfer      = tx_valid_o & tx_ready_i;
  assign last_xfer = xfer & tx_last_o;
  assign restart   = ((state == IDLE) & snap_i) | (last_xfer & (pending | snap_i));
  assign nidx      = widx + 6'd1;
  assign busy_o    = (state != IDLE) | pending;

  // Read address always points at the word after the one being loaded, so the
  // register value is ready on reg_data_i when that word's turn comes.
  always_comb begin
    addr_next = '0;
    if (nidx >= 6'(LAST))
      addr_next = 5'(NUM_REGS - 1);
    else if (nidx >= 6'd3)
      addr_next = 5'(nidx - 6'd3);
  end

  always_comb begin
    data_next = reg_data_i;
    case (nidx)
      6'd1:    data_next = 32'(cap_stl);
      6'd2:    data_next = 32'(cap_fls);
      6'd3:    data_next = cap_pc;
      default: data_next = reg_data_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      widx       <= '0;
      cyc        <= '0;
      stl        <= '0;
      fls        <= '0;
      cap_stl    <= '0;
      cap_fls    <= '0;
      cap_pc     <= '0;
      pending    <= 1'b0;
      reg_addr_o <= '0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
      tx_last_o  <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      if (start_i) begin
        cyc <= cyc + 1'b1;
        if (stall_i) stl <= stl + 1'b1;
        if (flush_i) fls <= fls + 1'b1;
      end

      // Capture uses the counter values from before this edge's increment.
      if (restart) begin
        state      <= HDR;
        widx       <= '0;
        cap_stl    <= stl;
        cap_fls    <= fls;
        cap_pc     <= pc_i;
        reg_addr_o <= '0;
        tx_valid_o <= 1'b1;
        tx_data_o  <= 32'(cyc);
        tx_last_o  <= 1'b0;
      end else if (last_xfer) begin
        state      <= IDLE;
        widx       <= '0;
        reg_addr_o <= '0;
        tx_valid_o <= 1'b0;
        tx_last_o  <= 1'b0;
      end else if (xfer) begin
        state      <= (nidx >= 6'd4) ? REGS : HDR;
        widx       <= nidx;
        reg_addr_o <= addr_next;
        tx_data_o  <= data_next;
        tx_last_o  <= (nidx == 6'(LAST));
      end

      if (restart)
        pending <= 1'b0;
      else if ((state != IDLE) && snap_i) begin
        if (pending)
          overrun_o <= 1'b1;
        else
          pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_trace_tx.sv
// Bench for cpu_trace_tx: directed record checks plus randomized traffic
// compared every cycle against a queue-based record model.
module tb_cpu_trace_tx;
  localparam int N   = 32;
  localparam int TOT = N + 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, stall = 1'b0, flush = 1'b0, snap = 1'b0, ready = 1'b0;
  logic [31:0] pc = '0;
  logic [4:0]  addr, addr_s;
  logic [31:0] rdata, rdata_s, data, data_s;
  logic        valid, last, busy, ovr;
  logic        valid_s, last_s, busy_s, ovr_s;
  logic [31:0] regs [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rdata   = regs[addr];
  assign rdata_s = regs[addr_s];

  cpu_trace_tx #(.NUM_REGS(N), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall), .flush_i(flush),
    .pc_i(pc), .snap_i(snap), .reg_addr_o(addr), .reg_data_i(rdata),
    .tx_valid_o(valid), .tx_ready_i(ready), .tx_data_o(data), .tx_last_o(last),
    .busy_o(busy), .overrun_o(ovr));

  cpu_trace_tx #(.NUM_REGS(8), .CNT_W(4)) dut_s (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall), .flush_i(flush),
    .pc_i(pc), .snap_i(snap), .reg_addr_o(addr_s), .reg_data_i(rdata_s),
    .tx_valid_o(valid_s), .tx_ready_i(ready), .tx_data_o(data_s), .tx_last_o(last_s),
    .busy_o(busy_s), .overrun_o(ovr_s));

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: a record is a queue of words; its front is the word on the link.
  logic [31:0] m_q[$];
  bit          m_valid = 0, m_pend = 0, m_ovr = 0;
  logic [31:0] m_cyc = '0, m_stl = '0, m_fls = '0;
  bit          m_was, m_xf, m_lst, m_rs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_valid = 0; m_pend = 0; m_ovr = 0;
      m_cyc = '0; m_stl = '0; m_fls = '0;
    end else begin
      m_was = m_valid;
      m_xf  = m_was && ready;
      m_lst = m_xf && (m_q.size() == 1);
      m_rs  = (!m_was && snap) || (m_lst && (m_pend || snap));
      if (m_xf) void'(m_q.pop_front());
      if (m_rs) begin
        m_q.delete();
        m_q.push_back(m_cyc);
        m_q.push_back(m_stl);
        m_q.push_back(m_fls);
        m_q.push_back(pc);
        for (int i = 0; i < N; i++) m_q.push_back(regs[i]);
        m_valid = 1;
        m_pend  = 0;
      end else if (m_lst) begin
        m_valid = 0;
      end else if (m_was && snap) begin
        if (m_pend) m_ovr = 1;
        else        m_pend = 1;
      end
      if (start) begin
        m_cyc = m_cyc + 1;
        if (stall) m_stl = m_stl + 1;
        if (flush) m_fls = m_fls + 1;
      end
    end
  end

  int cur;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", valid, 32'(m_valid));
      chk("busy", busy, 32'(m_valid || m_pend));
      chk("overrun", ovr, 32'(m_ovr));
      if (m_valid && m_q.size() > 0) begin
        cur = TOT - m_q.size();
        chk("data", data, m_q[0]);
        chk("last", last, 32'(m_q.size() == 1));
        chk("reg_addr", addr, (cur < 3) ? 0 : ((cur >= TOT - 1) ? N - 1 : cur - 3));
      end
      chk("small_addr_bound", 32'(addr_s <= 5'd7), 1);
    end
  end

  logic [31:0] got[$];
  int last_at = -1;
  int lasts   = 0;
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (last) begin
        last_at = got.size();
        lasts++;
      end
      got.push_back(data);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit st, input bit sl, input bit fl, input bit sn, input bit rd);
    start = st; stall = sl; flush = fl; snap = sn; ready = rd;
    step();
  endtask

  task automatic clear_got();
    got.delete();
    last_at = -1;
    lasts   = 0;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("wait_words", 32'(got.size() >= n), 1);
  endtask

  task automatic check_regs(input string name, input int base);
    int bad = 0;
    for (int i = 0; i < N; i++)
      if (got.size() <= base + 4 + i || got[base + 4 + i] !== 32'(i * 3)) bad++;
    chk(name, bad, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3);
    rst_n = 1'b0;
    step();
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_addr", addr, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // Counted run, then one snapshot with a free-running sink.
    for (int c = 1; c <= 10; c++) drive(1, c == 3 || c == 4, c == 6, 0, 1);
    pc = 32'h1000_0028;
    drive(0, 0, 0, 1, 1);
    snap = 0;
    wait_words(36, 200);
    step(); step();
    chk("t1_w0", got[0], 10);
    chk("t1_w1", got[1], 2);
    chk("t1_w2", got[2], 1);
    chk("t1_w3", got[3], 32'h1000_0028);
    check_regs("t1_regs", 0);
    chk("t1_count", got.size(), 36);
    chk("t1_last_at", last_at, 35);
    chk("t1_valid_drop", valid, 0);

    // Sink alternates ready every cycle.
    clear_got();
    drive(0, 0, 0, 1, 1);
    snap = 0;
    for (int k = 0; k < 300 && lasts < 1; k++) begin
      ready = ~ready;
      step();
    end
    ready = 1;
    step(); step();
    chk("t2_count", got.size(), 36);
    chk("t2_w0", got[0], 10);
    check_regs("t2_regs", 0);
    chk("t2_last_at", last_at, 35);

    // Requests during a record: first pends, second overruns.
    clear_got();
    drive(1, 0, 0, 1, 1);
    snap = 0;
    wait_words(5, 50);
    drive(1, 0, 0, 1, 1);
    snap = 0;
    wait_words(9, 50);
    drive(1, 0, 0, 1, 1);
    snap = 0;
    chk("t3_overrun", ovr, 1);
    chk("t3_busy", busy, 1);
    wait_words(72, 300);
    start = 0;
    step(); step();
    chk("t3_lasts", lasts, 2);
    chk("t3_last_at", last_at, 71);
    check_regs("t3_regs2", 36);

    // Reset in the middle of a record.
    clear_got();
    drive(0, 0, 0, 1, 1);
    snap = 0;
    wait_words(20, 50);
    rst_n = 0;
    #1;
    chk("t4_valid", valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_overrun", ovr, 0);
    chk("t4_addr", addr, 0);
    step(); step();
    rst_n = 1;
    clear_got();
    for (int k = 0; k < 30; k++) step();
    chk("t4_no_words", got.size(), 0);

    // Counter wrap on the narrow instance; counters restarted from reset.
    for (int c = 0; c < 18; c++) drive(1, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 1);
    snap = 0;
    chk("t5_small_valid", valid_s, 1);
    chk("t5_small_w0", data_s, 2);
    chk("t5_w0", data, 18);
    wait_words(36, 200);
    step(); step();

    // Randomized traffic against the model.
    rst_n = 0;
    step();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    rst_n = 1;
    step();
    for (int k = 0; k < 3000; k++) begin
      pc = $urandom;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7);
    end
    snap = 0;
    ready = 1;
    for (int k = 0; k < 200; k++) step();
    chk("rand_idle", valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
